// File: rtl/error_report_packer.sv
// rtl/error_report_packer.sv - captures flushed error entries and frames them as header/count/data/check bytes
// Build option ERR_PKT_CRC8_EN: check byte is CRC-8 (poly 0x07) instead of the additive sum.
module error_report_packer #(
  parameter int         DEPTH        = 8,
  parameter int         IDLE_TIMEOUT = 16,
  parameter logic [7:0] HEADER_BYTE  = 8'hE5
) (
  input  logic        sysClk,
  input  logic        rst,
  input  logic        in_report_req,
  output logic        out_start_flush_error_reg,
  input  logic [22:0] in_error_reg,
  input  logic        in_valid_error_reg,
  output logic [7:0]  out_byte,
  output logic        out_byte_valid,
  input  logic        in_byte_ready,
  output logic        out_busy,
  output logic        out_report_done
);
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_C   = 7'(DEPTH);
  localparam logic [7:0] TIMEOUT_C = 8'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_HDR, S_CNT, S_DATA, S_CSUM, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  timeout_q, timeout_d;
  logic        seen_q, seen_d;
  logic [6:0]  rd_idx_q, rd_idx_d;
  logic [1:0]  byte_sel_q, byte_sel_d;
  logic        wr_en;
  logic [7:0]  tx_byte;
  logic [7:0]  csum_next;
  logic [22:0] rd_entry;
  logic [22:0] mem_q [DEPTH];

  assign rd_entry = mem_q[rd_idx_q[AW-1:0]];

`ifdef ERR_PKT_CRC8_EN
  err_pkt_crc8_byte u_crc (
    .crc_in  (csum_q),
    .data_in (tx_byte),
    .crc_out (csum_next)
  );
`else
  assign csum_next = csum_q + tx_byte;
`endif

  // Byte mux is kept apart from the FSM so the checksum path has no false loop through it.
  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      S_HDR:  tx_byte = HEADER_BYTE;
      S_CNT:  tx_byte = {overflow_q, count_q};
      S_DATA: begin
        case (byte_sel_q)
          2'd0:    tx_byte = {1'b0, rd_entry[22:16]};
          2'd1:    tx_byte = rd_entry[15:8];
          default: tx_byte = rd_entry[7:0];
        endcase
      end
      S_CSUM: tx_byte = csum_q;
      default: tx_byte = 8'h00;
    endcase
  end

  assign out_byte       = tx_byte;
  assign out_byte_valid = (state_q == S_HDR) || (state_q == S_CNT) ||
                          (state_q == S_DATA) || (state_q == S_CSUM);

  always_comb begin
    state_d                   = state_q;
    count_d                   = count_q;
    overflow_d                = overflow_q;
    csum_d                    = csum_q;
    timeout_d                 = timeout_q;
    seen_d                    = seen_q;
    rd_idx_d                  = rd_idx_q;
    byte_sel_d                = byte_sel_q;
    wr_en                     = 1'b0;
    out_start_flush_error_reg = 1'b0;
    out_report_done           = 1'b0;
    out_busy                  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (in_report_req) begin
          state_d    = S_FLUSH;
          count_d    = 7'd0;
          overflow_d = 1'b0;
          csum_d     = 8'h00;
          timeout_d  = 8'h00;
          seen_d     = 1'b0;
        end
      end
      S_FLUSH: begin
        out_start_flush_error_reg = 1'b1;
        if (in_valid_error_reg) begin
          seen_d    = 1'b1;
          timeout_d = 8'h00;
          if (count_q == DEPTH_C) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 7'd1;
          end
        end else if (seen_q || (timeout_q == TIMEOUT_C - 8'd1)) begin
          state_d = S_HDR;
        end else begin
          timeout_d = timeout_q + 8'd1;
        end
      end
      S_HDR: begin
        if (in_byte_ready) state_d = S_CNT;
      end
      S_CNT: begin
        if (in_byte_ready) begin
          csum_d     = csum_next;
          rd_idx_d   = 7'd0;
          byte_sel_d = 2'd0;
          state_d    = (count_q == 7'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (in_byte_ready) begin
          csum_d = csum_next;
          if (byte_sel_q == 2'd2) begin
            byte_sel_d = 2'd0;
            if (rd_idx_q == count_q - 7'd1) state_d = S_CSUM;
            else rd_idx_d = rd_idx_q + 7'd1;
          end else begin
            byte_sel_d = byte_sel_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        if (in_byte_ready) state_d = S_DONE;
      end
      S_DONE: begin
        out_report_done = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 7'd0;
      overflow_q <= 1'b0;
      csum_q     <= 8'h00;
      timeout_q  <= 8'h00;
      seen_q     <= 1'b0;
      rd_idx_q   <= 7'd0;
      byte_sel_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      csum_q     <= csum_d;
      timeout_q  <= timeout_d;
      seen_q     <= seen_d;
      rd_idx_q   <= rd_idx_d;
      byte_sel_q <= byte_sel_d;
    end
  end

  // Entry storage needs no reset: only slots below count_q are ever read.
  always_ff @(posedge sysClk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= in_error_reg;
  end
endmodule

`ifdef ERR_PKT_CRC8_EN
module err_pkt_crc8_byte (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[7] ? ((crc_out << 1) ^ 8'h07) : (crc_out << 1);
    end
  end
endmodule
`endif
